// File: rtl/latch_wr_pkg.sv
// Shared types and elaboration helpers for the latch write driver.
// The optional LATCH_WRITE_READBACK_EN build adds a readback check in the top.
package latch_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } wr_state_e;

  // Phase counter holds (longest phase - 1); the floor of 1 keeps the width >= 1.
  function automatic int phase_cnt_w(input int setup_cyc, input int open_cyc,
                                     input int hold_cyc);
    int longest;
    longest = 1;
    if (setup_cyc > longest) longest = setup_cyc;
    if (open_cyc > longest) longest = open_cyc;
    if (hold_cyc > longest) longest = hold_cyc;
    return $clog2(longest + 1);
  endfunction

  function automatic bit params_legal(input int width, input int setup_cyc,
                                      input int open_cyc, input int hold_cyc,
                                      input int cnt_w);
    return (width >= 1) && (setup_cyc >= 0) && (open_cyc >= 1) &&
           (hold_cyc >= 0) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/latch_wr_phase_timer.sv
// Loadable down-counter shared by the SETUP, OPEN and HOLD phases.
// last is high in the final cycle of the phase that was loaded.
module latch_wr_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/latch_write_driver.sv
// Drives D and G of a downstream transparent latch through setup/open/hold windows.
// Define LATCH_WRITE_READBACK_EN to add i_q/o_err sticky readback checking.
module latch_write_driver #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_d,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_wr_cnt
`ifdef LATCH_WRITE_READBACK_EN
  ,
  input  logic [WIDTH-1:0] i_q,
  output logic             o_err
`endif
);

  import latch_wr_pkg::*;

  localparam int CW       = phase_cnt_w(SETUP_CYC, OPEN_CYC, HOLD_CYC);
  localparam int SETUP_LD = (SETUP_CYC > 0) ? SETUP_CYC - 1 : 0;
  localparam int OPEN_LD  = (OPEN_CYC > 0) ? OPEN_CYC - 1 : 0;
  localparam int HOLD_LD  = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

  generate
    if (!params_legal(WIDTH, SETUP_CYC, OPEN_CYC, HOLD_CYC, CNT_W)) begin : g_bad_params
      $error("latch_write_driver: illegal parameters (OPEN_CYC must be >= 1)");
    end
  endgenerate

  // Handshake: a word transfers on a rising edge where i_valid && o_ready;
  // o_ready is a flop that is high only in IDLE, so nothing is buffered.
  wr_state_e     state;
  wr_state_e     state_next;
  logic          accept;
  logic          phase_last;
  logic          load;
  logic [CW-1:0] load_val;
  logic          en_next;
  logic          ready_next;
  logic          done_next;

  assign accept = i_valid && o_ready;
  assign o_busy = (state != IDLE);

  latch_wr_phase_timer #(
    .W(CW)
  ) u_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (load),
    .load_val(load_val),
    .last    (phase_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = (SETUP_CYC == 0) ? OPEN : SETUP;
      end
      SETUP: begin
        if (phase_last) state_next = OPEN;
      end
      OPEN: begin
        if (phase_last) state_next = (HOLD_CYC == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (phase_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Every phase change reloads the timer with that phase's length minus one.
  always_comb begin
    load     = (state_next != state);
    load_val = '0;
    case (state_next)
      SETUP:   load_val = CW'(SETUP_LD);
      OPEN:    load_val = CW'(OPEN_LD);
      HOLD:    load_val = CW'(HOLD_LD);
      default: load_val = '0;
    endcase
    en_next    = (state_next == OPEN);
    ready_next = (state_next == IDLE);
    done_next  = (state != IDLE) && (state_next == IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_d      <= '0;
      o_en     <= 1'b0;
      o_ready  <= 1'b0;
      o_done   <= 1'b0;
      o_wr_cnt <= '0;
    end else begin
      if (accept) o_d <= i_data;
      o_en    <= en_next;
      o_ready <= ready_next;
      o_done  <= done_next;
      if (done_next) o_wr_cnt <= o_wr_cnt + CNT_W'(1);
    end
  end

`ifdef LATCH_WRITE_READBACK_EN
  // done_next marks the last OPEN/HOLD cycle, when the latch must hold o_d.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (done_next && (i_q != o_d)) begin
      o_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/latch_write_driver.md
Name: latch_write_driver

Overview:
- Transmitter side of the level-sensitive latch interface: drives the data bus and latch enable so a downstream transparent latch (G=en, D=data) captures each word cleanly.
- Accepts words on a valid/ready handshake and sequences each write through setup, open and hold windows.
- Data is stable for the whole enable window, and enable is a flop output, so it never glitches.
- Sits in front of the latch-based storage cells in the misc/latch test designs, replacing ad-hoc combinational enables.

Parameters:
- WIDTH, 8, data bus width.
- SETUP_CYC, 1, cycles data is stable before en rises (>=0).
- OPEN_CYC, 2, cycles en is high (>=1).
- HOLD_CYC, 1, cycles data stays stable after en falls (>=0).
- CNT_W, 8, width of completed-write counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  driver can accept a word.
- i_data  input  WIDTH  word to write.
- o_d  output  WIDTH  latch data bus (D).
- o_en  output  1  latch enable (G); registered.
- o_busy  output  1  write in progress (state != IDLE).
- o_done  output  1  one-cycle pulse after a write completes.
- o_wr_cnt  output  CNT_W  completed writes, wraps modulo 2^CNT_W.

Behaviour:
- Reset: the interface is one clock with synchronous active-high reset.
  - All outputs are forced on the first i_clk edge with i_rst=1: o_d=0, o_en=0, o_busy=0, o_done=0, o_wr_cnt=0, o_ready=0.
  - The state returns to IDLE.
  - o_ready rises in the first cycle after i_rst deasserts.
- States:
  - IDLE: o_ready=1. On i_valid&&o_ready, o_d<=i_data, the phase counter is loaded, and the next state is SETUP. If SETUP_CYC==0 the next state is OPEN instead.
  - SETUP: lasts SETUP_CYC cycles, o_en=0, then OPEN.
  - OPEN: o_en=1 for exactly OPEN_CYC cycles, then HOLD. If HOLD_CYC==0 it goes straight to IDLE.
  - HOLD: lasts HOLD_CYC cycles, o_en=0, then IDLE.
- o_done:
  - Pulses for exactly one cycle, in the first IDLE cycle after a completed write.
  - o_wr_cnt increments in that same cycle.
  - o_ready is 1 in the o_done cycle, so back-to-back writes are allowed.
- Timing:
  - Throughput is 1 word per (1+SETUP_CYC+OPEN_CYC+HOLD_CYC) cycles.
  - Latency from accept to o_en rising is SETUP_CYC+1 cycles.
- Stability:
  - o_d changes only on an accepting edge in IDLE. It never changes while o_en=1 or during HOLD.
  - o_en and o_d are both direct flop outputs; o_en has no combinational path from the inputs.
  - o_ready=0 in all non-IDLE states. i_valid/i_data are ignored outside IDLE; no buffering is performed.
- Counter: wraps from 2^CNT_W-1 to 0 without a flag.
- Reset mid-write: o_en drops at that edge and the write is abandoned. No o_done is produced and o_wr_cnt is not incremented.
- Phase counter: width is clog2 of max(SETUP_CYC,OPEN_CYC,HOLD_CYC,1)+1.

Optional Feature:
- Macro: LATCH_WRITE_READBACK_EN.
- When defined, two ports are added:
  - i_q  input  WIDTH  latch output (Q).
  - o_err  output  1  sticky readback mismatch.
- Check: in the last cycle before returning to IDLE (last HOLD cycle, or last OPEN cycle if HOLD_CYC==0), i_q is compared with o_d.
- Result: on mismatch, o_err<=1 and stays set until i_rst. o_err resets to 0.
- When not defined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package latch_wr_pkg holds:
  - the state enum (IDLE, SETUP, OPEN, HOLD);
  - the phase-counter width function;
  - parameter-legality checks (elaboration error if OPEN_CYC<1).
- Sub-module latch_wr_phase_timer is natural: loadable down-counter with a last-cycle flag, shared by all three phases.

Test Plan:
- Reset: i_rst high 2 cycles mid-OPEN -> o_en=0 and o_d=0 at the next edge; no o_done; o_wr_cnt=0; o_ready=1 the cycle after release.
- Single write, defaults: i_data=8'hA5 accepted at cycle t -> o_en=1 at t+2..t+3, o_d=8'hA5 from t+1 to t+4, o_done at t+5, o_wr_cnt=1.
- Back-to-back: i_valid held high with 8'h01, 8'h02, 8'h03 -> accepts every 5 cycles, o_en high 2 cycles per word, o_d never changes while o_en=1, o_wr_cnt=3.
- Edge parameters: SETUP_CYC=0, HOLD_CYC=0, OPEN_CYC=1 -> o_en high the cycle after accept, accepts every 2 cycles; CNT_W=2 with 5 writes -> o_wr_cnt=1.
- Ignored input: i_data toggling and i_valid pulses during SETUP/OPEN/HOLD -> o_ready=0, o_d unchanged, no extra write.
- Readback (LATCH_WRITE_READBACK_EN): latch model feeds i_q correctly -> o_err=0; force i_q=8'h00 while writing 8'hFF -> o_err=1 after the last HOLD cycle and still 1 after a following good write.
